// File: rtl/approx_add_sweep_ctrl_pkg.sv
// Shared types and width helpers for the approximate-adder sweep controller.
package approx_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_EMIT,
        S_FINISH
    } sweep_state_t;

    localparam int OP_W_DEF = 8;

    function automatic int sum_w(input int op_w);
        return op_w + 1;
    endfunction

    function automatic int addr_w(input int op_w);
        return 2 * op_w;
    endfunction

    function automatic int cnt_w(input int op_w);
        return 2 * op_w + 1;
    endfunction

    // Holds 2^(2*op_w) * (2^(op_w+1)-1) without overflow.
    function automatic int acc_w(input int op_w);
        return 3 * op_w + 1;
    endfunction

endpackage

// File: rtl/approx_add_sweep_ctrl_if.sv
// LUT entry stream: one entry per operand pair, valid/ready handshake.
interface approx_add_sweep_ctrl_if
    import approx_sweep_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
);
    logic                      lut_valid;
    logic                      lut_ready;
    logic [addr_w(OP_W)-1:0]   lut_addr;
    logic [sum_w(OP_W)-1:0]    lut_data;

    modport master (output lut_valid, lut_addr, lut_data, input  lut_ready);
    modport slave  (input  lut_valid, lut_addr, lut_data, output lut_ready);
endinterface

// File: rtl/approx_add_sweep_ctrl_err.sv
// Error of one adder result against the exact sum, plus the compares the
// metric accumulators need.
module approx_err_metric #(
    parameter int OP_W = 8
) (
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic [OP_W:0]   o,
    input  logic [OP_W:0]   wce,
    output logic [OP_W:0]   err,
    output logic            nz,
    output logic            gt
);
    logic [OP_W:0] exact;

    assign exact = {1'b0, a} + {1'b0, b};
    // Subtract the smaller from the larger so the magnitude never wraps.
    assign err   = (o >= exact) ? (o - exact) : (exact - o);
    assign nz    = |err;
    assign gt    = err > wce;
endmodule

// File: rtl/approx_add_sweep_ctrl.sv
// Walks every (A,B) pair through an external approximate adder, streams the
// results as LUT entries and accumulates error metrics for the sweep.
module approx_add_sweep_ctrl
    import approx_sweep_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [OP_W-1:0]          dut_a,
    output logic [OP_W-1:0]          dut_b,
    input  logic [sum_w(OP_W)-1:0]   dut_o,
    approx_add_sweep_ctrl_if.master  lut,
    output logic [cnt_w(OP_W)-1:0]   err_cnt,
    output logic [sum_w(OP_W)-1:0]   wce,
    output logic [acc_w(OP_W)-1:0]   sum_abs_err
);
    localparam int SW  = sum_w(OP_W);
    localparam int AW  = addr_w(OP_W);
    localparam int CW  = cnt_w(OP_W);
    localparam int ACW = acc_w(OP_W);

    sweep_state_t   state, state_nxt;
    logic [SW-1:0]  err;
    logic           err_nz, err_gt;
    logic [AW-1:0]  addr, addr_inc;
    logic           last;
    logic [SW-1:0]  lut_data_q;

    assign addr     = {dut_a, dut_b};
    assign addr_inc = addr + AW'(1);
    assign last     = &addr;

    assign lut.lut_addr = addr;
    assign lut.lut_data = lut_data_q;

    approx_err_metric #(.OP_W(OP_W)) u_err (
        .a   (dut_a),
        .b   (dut_b),
        .o   (dut_o),
        .wce (wce),
        .err (err),
        .nz  (err_nz),
        .gt  (err_gt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        done          = 1'b0;
        lut.lut_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_DRIVE;
            end
            S_DRIVE:  state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = S_EMIT;
            S_EMIT: begin
                lut.lut_valid = 1'b1;
                if (lut.lut_ready) state_nxt = last ? S_FINISH : S_DRIVE;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
        // Abort beats start and any same-cycle handshake.
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_a       <= '0;
            dut_b       <= '0;
            lut_data_q  <= '0;
            err_cnt     <= '0;
            wce         <= '0;
            sum_abs_err <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE: if (start) begin
                    dut_a       <= '0;
                    dut_b       <= '0;
                    err_cnt     <= '0;
                    wce         <= '0;
                    sum_abs_err <= '0;
                end
                // SAMPLE is visited once per pair, so metrics update exactly once.
                S_SAMPLE: begin
                    lut_data_q  <= dut_o;
                    err_cnt     <= err_cnt + CW'(err_nz);
                    sum_abs_err <= sum_abs_err + ACW'(err);
                    if (err_gt) wce <= err;
                end
                S_EMIT: if (lut.lut_ready && !last) {dut_a, dut_b} <= addr_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_add_sweep_ctrl.sv
// Directed bench for approx_add_sweep_ctrl at OP_W=4 so full sweeps stay short;
// a bench-side adder model feeds dut_o.
module tb_approx_add_sweep_ctrl;
    localparam int OP_W = 4;
    localparam int AW   = 2 * OP_W;
    localparam int N    = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done;
    logic [OP_W-1:0]   dut_a, dut_b;
    logic [OP_W:0]     dut_o;
    logic [2*OP_W:0]   err_cnt;
    logic [OP_W:0]     wce;
    logic [3*OP_W:0]   sum_abs_err;
    int                mode = 0;
    int                checks = 0;
    int                failures = 0;

    approx_add_sweep_ctrl_if #(.OP_W(OP_W)) lut ();

    approx_add_sweep_ctrl #(.OP_W(OP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .dut_a       (dut_a),
        .dut_b       (dut_b),
        .dut_o       (dut_o),
        .lut         (lut),
        .err_cnt     (err_cnt),
        .wce         (wce),
        .sum_abs_err (sum_abs_err)
    );

    always #5 clk = ~clk;

    // 0: exact adder, 1: OR-based low 3 bits, 2: stuck at all ones
    function automatic logic [4:0] model(input int md, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (md)
            0:       r = {1'b0, a} + {1'b0, b};
            1:       r = {{1'b0, a[3]} + {1'b0, b[3]}, a[2] | b[2], a[1] | b[1], 1'b1};
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    always_comb dut_o = model(mode, dut_a, dut_b);

    function automatic int pair_err(input int md, input int idx);
        logic [7:0] p;
        int ex, o;
        p  = idx[7:0];
        ex = int'(p[7:4]) + int'(p[3:0]);
        o  = int'(model(md, p[7:4], p[3:0]));
        return (o > ex) ? o - ex : ex - o;
    endfunction

    function automatic int prefix_sum(input int md, input int last_idx);
        int s = 0;
        for (int i = 0; i <= last_idx; i++) s += pair_err(md, i);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for a given lut_addr with a given lut_valid, bounded by budget cycles.
    task automatic wait_for(input string tag, input logic [7:0] a, input logic v, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (lut.lut_addr == a && lut.lut_valid == v) begin
                ok = 1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic full_sweep(input int md, input string tag);
        int idx = 0, bad = 0, dn = 0, ecnt = 0, ewce = 0, esum = 0, e;
        mode = md;
        lut.lut_ready = 1'b1;
        @(negedge clk);
        pulse_start();
        for (int cyc = 0; cyc < 4 * N + 20; cyc++) begin
            if (lut.lut_valid && lut.lut_ready) begin
                if (lut.lut_addr !== AW'(idx) ||
                    lut.lut_data !== model(md, lut.lut_addr[7:4], lut.lut_addr[3:0])) bad++;
                e = pair_err(md, idx);
                if (e != 0) ecnt++;
                if (e > ewce) ewce = e;
                esum += e;
                idx++;
            end
            if (done) begin
                dn++;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(dn), 64'd1);
        chk({tag, "_entries"}, 64'(idx), 64'(N));
        chk({tag, "_bad_entries"}, 64'(bad), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(ecnt));
        chk({tag, "_wce"}, 64'(wce), 64'(ewce));
        chk({tag, "_sum"}, 64'(sum_abs_err), 64'(esum));
        @(negedge clk);
        chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int ec, es, gap;
        bit stable;
        lut.lut_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {60'd0, busy, done, lut.lut_valid, 1'b0}, 64'd0);
        chk("reset_ops", {48'd0, dut_a, dut_b, lut.lut_addr}, 64'd0);
        chk("reset_metrics", {lut.lut_data, err_cnt, wce, sum_abs_err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        full_sweep(0, "exact");
        chk("exact_zero", {err_cnt, wce, sum_abs_err}, 64'd0);
        full_sweep(1, "orlow");
        chk("orlow_wce7", 64'(wce), 64'd7);
        full_sweep(2, "stuck");
        chk("stuck_const", {err_cnt, wce, sum_abs_err}, {9'd256, 5'd31, 13'd4096});

        // abort and start together in IDLE
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_start_idle", 64'(busy), 64'd0);

        // backpressure at 0x12 with the stuck adder so every pair has error
        mode = 2;
        pulse_start();
        wait_for("bp_reach_drive", 8'h12, 1'b0, 200);
        lut.lut_ready = 1'b0;
        wait_for("bp_reach_emit", 8'h12, 1'b1, 5);
        ec = int'(err_cnt);
        es = int'(sum_abs_err);
        chk("bp_sum_once", 64'(es), 64'(prefix_sum(2, 'h12)));
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(lut.lut_valid && lut.lut_addr == 8'h12 && lut.lut_data == 5'h1F &&
                  int'(err_cnt) == ec && int'(sum_abs_err) == es)) stable = 0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        lut.lut_ready = 1'b1;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lut.lut_valid) break;
            gap++;
        end
        chk("bp_gap", 64'(gap), 64'd2);
        chk("bp_next_addr", 64'(lut.lut_addr), 64'h13);
        chk("bp_next_cnt", 64'(err_cnt), 64'(ec + 1));

        // start while busy must not restart the sweep
        pulse_start();
        wait_for("start_ignored", 8'h14, 1'b1, 6);

        // abort in EMIT at 0x34, same cycle as a ready handshake
        wait_for("abort_reach", 8'h34, 1'b1, 400);
        ec = int'(err_cnt);
        es = int'(sum_abs_err);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ctrl", {61'd0, busy, lut.lut_valid, done}, 64'd0);
        chk("abort_cnt_hold", 64'(err_cnt), 64'(ec));
        chk("abort_sum_hold", 64'(sum_abs_err), 64'(es));
        chk("abort_sum_val", 64'(es), 64'(prefix_sum(2, 'h34)));
        stable = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) stable = 0;
        end
        chk("abort_no_done", 64'(stable), 64'd1);

        // restart clears metrics and begins at address 0
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_clear", {err_cnt, wce, sum_abs_err}, 64'd0);
        wait_for("restart_addr0", 8'h00, 1'b1, 5);

        // one-cycle reset mid-sweep
        wait_for("rst_reach", 8'h05, 1'b1, 40);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", {60'd0, busy, done, lut.lut_valid, 1'b0}, 64'd0);
        chk("midrst_ops", {48'd0, dut_a, dut_b, lut.lut_addr}, 64'd0);
        chk("midrst_metrics", {lut.lut_data, err_cnt, wce, sum_abs_err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
